mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Memory-access stage: registers EX results toward the write-back stage and executes loads/stores on a req/ack data bus.
//  Sizes and aligns bus accesses, sign/zero-extends load data, and stalls upstream while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles waiting for bus_ack_i before abort; 0 = wait forever
// PORTS (pass-through pairs: _i from EX, _o registered to WB)
//  clk            in   1   clock, posedge
//  rst            in   1   asynchronous active-high reset
//  valid_i        in   1   EX holds a valid instruction this cycle
//  flush_i        in   1   discard the instruction offered this cycle
//  stall_o        out  1   registered; EX must hold its outputs while high
//  inst_i/_o      i/o  32  instruction word
//  inst_addr_i/_o i/o  32  instruction address
//  reg_we_i/_o    i/o  1   GPR write enable
//  reg_waddr_i/_o i/o  5   GPR write address
//  reg_wdata_i/_o i/o  32  ALU result in; ALU result or load data out
//  csr_we_i/_o    i/o  1   CSR write enable
//  csr_waddr_i/_o i/o  32  CSR address
//  csr_wdata_i/_o i/o  32  CSR write data
//  jump_flag_i/_o i/o  1   jump taken
//  jump_addr_i/_o i/o  32  jump target
//  mem_req_i      in   1   instruction is a load/store
//  mem_we_i       in   1   1 = store, 0 = load
//  mem_funct3_i   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_addr_i     in   32  byte address
//  mem_wdata_i    in   32  store data (low bits significant)
//  valid_o        out  1   outputs to WB valid this cycle
//  exc_o          out  2   1-cycle pulse with valid_o: 01 misaligned/illegal size, 10 bus timeout
//  bus_req_o      out  1   transaction request
//  bus_we_o       out  1   write
//  bus_addr_o     out  32  word address, [1:0] = 0
//  bus_sel_o      out  4   byte lane enables
//  bus_wdata_o    out  32  lane-replicated store data
//  bus_ack_i      in   1   transaction complete; bus_rdata_i valid on the same cycle
//  bus_rdata_i    in   32  read word
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0. Async assertion drops bus_req_o immediately; in-flight transaction is lost.
//  States: IDLE, BUSY. stall_o = (state == BUSY).
//  IDLE, valid_i && !flush_i, no mem_req_i: capture into output regs; valid_o = 1 next cycle (1-cycle latency).
//  IDLE, valid_i && !flush_i, mem_req_i, aligned, legal size: latch request; next cycle -> BUSY with bus_req_o = 1, valid_o = 0.
//  Misaligned (H with addr[0], W with addr[1:0] != 0) or illegal funct3: no bus access; next cycle valid_o = 1, exc_o = 01, reg_we_o = 0.
//  IDLE, !valid_i or flush_i: bubble (valid_o = 0, reg_we_o = 0, csr_we_o = 0, jump_flag_o = 0).
//  BUSY: bus_req/we/addr/sel/wdata held stable until bus_ack_i. On ack: drop bus_req_o, go to IDLE, present result next cycle (valid_o = 1).
//   Load ack: reg_wdata_o = extracted, extended lane. Store ack: reg_we_o = 0.
//  flush_i is ignored in BUSY (the outstanding op is older than the flush); stores are never aborted.
//  Timeout: counter increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES: drop request, go to IDLE, next cycle valid_o = 1, exc_o = 10, reg_we_o = 0.
//  Ack on the same cycle as expiry counts as success.
//  Lanes: B sel = 1<<a[1:0], wdata = {4{b}}; H sel = a[1] ? 1100 : 0011, wdata = {2{h}}; W sel = 1111.
//  Loads use the same sel. B/H are sign-extended, BU/HU zero-extended.
//  Back-to-back: a new instruction is accepted in the IDLE cycle right after BUSY exits; no extra bubble.
// STRUCTURE
//  defines.v: bus widths, funct3 size codes, exc_o codes. State encoding is local localparam.
//  Sub-module mem_align (combinational): sel/wdata generation, load extraction/extension, misalign detect.
// TESTING
//  ALU op, valid_i=1, reg_wdata_i=0x1234 -> next cycle valid_o=1, reg_wdata_o=0x1234, stall_o=0.
//  LB addr 0x103, ack after 3 cycles with rdata=0x80FF_FF00 -> bus_addr_o=0x100, sel=1000, reg_wdata_o=0xFFFF_FF80, stall_o high 4 cycles.
//  SH addr 0x102, wdata=0xABCD -> sel=1100, bus_wdata_o=0xABCD_ABCD, valid_o with reg_we_o=0 after ack.
//  LW addr 0x101 -> no bus_req_o, valid_o=1, exc_o=01, reg_we_o=0.
//  TIMEOUT_CYCLES=4, no ack -> bus_req_o drops after 4 BUSY cycles, exc_o=10. Flush during BUSY -> transaction completes.
//  rst asserted mid-BUSY -> bus_req_o=0 asynchronously. After release -> IDLE, accepts a new op.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and codes for the memory-access stage: access-size encodings,
// exception codes and the write-back bundle carried through the stage.
package mem_lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_addr;
    logic            reg_we;
    logic [4:0]      reg_waddr;
    logic [XLEN-1:0] reg_wdata;
    logic            csr_we;
    logic [XLEN-1:0] csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            jump_flag;
    logic [XLEN-1:0] jump_addr;
  } wb_t;

endpackage

// File: rtl/mem_lsu_if.sv
// EX/WB pass-through and req/ack data-bus signals of the memory-access stage.
// slave = the stage itself, master = the surrounding pipeline and bus.
interface mem_lsu_if;
  logic        valid_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] inst_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_addr_o;
  logic        reg_we_i;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_i;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_wdata_o;
  logic        csr_we_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_i;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_wdata_o;
  logic        jump_flag_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_i;
  logic [31:0] jump_addr_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        valid_o;
  logic [1:0]  exc_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport slave (
    input  valid_i, flush_i, inst_i, inst_addr_i, reg_we_i, reg_waddr_i, reg_wdata_i,
           csr_we_i, csr_waddr_i, csr_wdata_i, jump_flag_i, jump_addr_i,
           mem_req_i, mem_we_i, mem_funct3_i, mem_addr_i, mem_wdata_i,
           bus_ack_i, bus_rdata_i,
    output stall_o, inst_o, inst_addr_o, reg_we_o, reg_waddr_o, reg_wdata_o,
           csr_we_o, csr_waddr_o, csr_wdata_o, jump_flag_o, jump_addr_o,
           valid_o, exc_o, bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o
  );

  modport master (
    output valid_i, flush_i, inst_i, inst_addr_i, reg_we_i, reg_waddr_i, reg_wdata_i,
           csr_we_i, csr_waddr_i, csr_wdata_i, jump_flag_i, jump_addr_i,
           mem_req_i, mem_we_i, mem_funct3_i, mem_addr_i, mem_wdata_i,
           bus_ack_i, bus_rdata_i,
    input  stall_o, inst_o, inst_addr_o, reg_we_o, reg_waddr_o, reg_wdata_o,
           csr_we_o, csr_waddr_o, csr_wdata_o, jump_flag_o, jump_addr_o,
           valid_o, exc_o, bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables, store replication and misalign detect for
// the offered request; lane extraction and sign/zero extension for the returned word.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_sel,
  output logic [31:0] req_bus_wdata,
  output logic        req_bad,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    req_sel       = 4'b0000;
    req_bus_wdata = req_wdata;
    req_bad       = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: begin
        req_sel       = 4'b0001 << req_addr;
        req_bus_wdata = {4{req_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        req_sel       = req_addr[1] ? 4'b1100 : 4'b0011;
        req_bus_wdata = {2{req_wdata[15:0]}};
        req_bad       = req_addr[0];
      end
      F3_W: begin
        req_sel = 4'b1111;
        req_bad = |req_addr;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign shifted = ld_rdata >> {ld_addr, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'b0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'b0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: 1-cycle register toward WB for non-memory ops; loads/stores
// run on the req/ack bus with stall_o held high (EX frozen) until ack or timeout.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic      clk,
  input logic      rst,
  mem_lsu_if.slave lsu
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic          stall;
  logic          valid;
  logic [1:0]    exc;
  wb_t           wb_in;
  wb_t           wb_q;
  wb_t           pend;
  logic [CW-1:0] tmo_cnt;
  logic          expire;
  logic [2:0]    ld_funct3;
  logic [1:0]    ld_addr;
  logic          bus_req;
  logic          bus_we;
  logic [31:0]   bus_addr;
  logic [3:0]    bus_sel;
  logic [31:0]   bus_wdata;
  logic [3:0]    req_sel;
  logic [31:0]   req_bus_wdata;
  logic          req_bad;
  logic [31:0]   ld_data;

  always_comb begin
    wb_in           = '0;
    wb_in.inst      = lsu.inst_i;
    wb_in.inst_addr = lsu.inst_addr_i;
    wb_in.reg_we    = lsu.reg_we_i;
    wb_in.reg_waddr = lsu.reg_waddr_i;
    wb_in.reg_wdata = lsu.reg_wdata_i;
    wb_in.csr_we    = lsu.csr_we_i;
    wb_in.csr_waddr = lsu.csr_waddr_i;
    wb_in.csr_wdata = lsu.csr_wdata_i;
    wb_in.jump_flag = lsu.jump_flag_i;
    wb_in.jump_addr = lsu.jump_addr_i;
  end

  mem_lsu_align u_align (
    .req_funct3    (lsu.mem_funct3_i),
    .req_addr      (lsu.mem_addr_i[1:0]),
    .req_wdata     (lsu.mem_wdata_i),
    .req_sel       (req_sel),
    .req_bus_wdata (req_bus_wdata),
    .req_bad       (req_bad),
    .ld_funct3     (ld_funct3),
    .ld_addr       (ld_addr),
    .ld_rdata      (lsu.bus_rdata_i),
    .ld_data       (ld_data)
  );

  // Expiry fires in the BUSY cycle where the counter would reach the limit.
  assign expire = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stall     <= 1'b0;
      valid     <= 1'b0;
      exc       <= EXC_NONE;
      wb_q      <= '0;
      pend      <= '0;
      tmo_cnt   <= '0;
      ld_funct3 <= 3'b000;
      ld_addr   <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= 4'b0000;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          exc   <= EXC_NONE;
          wb_q  <= '0;
          if (lsu.valid_i && !lsu.flush_i) begin
            if (!lsu.mem_req_i) begin
              valid <= 1'b1;
              wb_q  <= wb_in;
            end else if (req_bad) begin
              valid       <= 1'b1;
              exc         <= EXC_MISALIGN;
              wb_q        <= wb_in;
              wb_q.reg_we <= 1'b0;
            end else begin
              state     <= BUSY;
              stall     <= 1'b1;
              pend      <= wb_in;
              tmo_cnt   <= '0;
              ld_funct3 <= lsu.mem_funct3_i;
              ld_addr   <= lsu.mem_addr_i[1:0];
              bus_req   <= 1'b1;
              bus_we    <= lsu.mem_we_i;
              bus_addr  <= {lsu.mem_addr_i[31:2], 2'b00};
              bus_sel   <= req_sel;
              bus_wdata <= req_bus_wdata;
            end
          end
        end
        BUSY: begin
          // flush_i is deliberately not looked at here: the outstanding op is older.
          if (lsu.bus_ack_i) begin
            state   <= IDLE;
            stall   <= 1'b0;
            bus_req <= 1'b0;
            tmo_cnt <= '0;
            valid   <= 1'b1;
            wb_q    <= pend;
            if (bus_we) wb_q.reg_we    <= 1'b0;
            else        wb_q.reg_wdata <= ld_data;
          end else if (expire) begin
            state       <= IDLE;
            stall       <= 1'b0;
            bus_req     <= 1'b0;
            tmo_cnt     <= '0;
            valid       <= 1'b1;
            exc         <= EXC_TIMEOUT;
            wb_q        <= pend;
            wb_q.reg_we <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu.stall_o     = stall;
  assign lsu.valid_o     = valid;
  assign lsu.exc_o       = exc;
  assign lsu.inst_o      = wb_q.inst;
  assign lsu.inst_addr_o = wb_q.inst_addr;
  assign lsu.reg_we_o    = wb_q.reg_we;
  assign lsu.reg_waddr_o = wb_q.reg_waddr;
  assign lsu.reg_wdata_o = wb_q.reg_wdata;
  assign lsu.csr_we_o    = wb_q.csr_we;
  assign lsu.csr_waddr_o = wb_q.csr_waddr;
  assign lsu.csr_wdata_o = wb_q.csr_wdata;
  assign lsu.jump_flag_o = wb_q.jump_flag;
  assign lsu.jump_addr_o = wb_q.jump_addr;
  assign lsu.bus_req_o   = bus_req;
  assign lsu.bus_we_o    = bus_we;
  assign lsu.bus_addr_o  = bus_addr;
  assign lsu.bus_sel_o   = bus_sel;
  assign lsu.bus_wdata_o = bus_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a write-back scoreboard; DUT built with
// TIMEOUT_CYCLES=4 so the expiry boundary is reachable in a few cycles.
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  exc;
  } exp_t;

  exp_t sb[$];

  mem_lsu_if lsu();

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (lsu)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    lsu.valid_i      = 1'b0;
    lsu.flush_i      = 1'b0;
    lsu.mem_req_i    = 1'b0;
    lsu.mem_we_i     = 1'b0;
    lsu.reg_we_i     = 1'b0;
  endtask

  task automatic op(input logic [31:0] inst, input logic mreq, input logic we,
                    input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] rwd);
    lsu.valid_i      = 1'b1;
    lsu.flush_i      = 1'b0;
    lsu.inst_i       = inst;
    lsu.inst_addr_i  = inst ^ 32'h0000_FFFF;
    lsu.reg_we_i     = 1'b1;
    lsu.reg_waddr_i  = inst[4:0];
    lsu.reg_wdata_i  = rwd;
    lsu.csr_we_i     = 1'b0;
    lsu.csr_waddr_i  = 32'h0;
    lsu.csr_wdata_i  = 32'h0;
    lsu.jump_flag_i  = 1'b0;
    lsu.jump_addr_i  = 32'h0;
    lsu.mem_req_i    = mreq;
    lsu.mem_we_i     = we;
    lsu.mem_funct3_i = f3;
    lsu.mem_addr_i   = addr;
    lsu.mem_wdata_i  = wd;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] wdata,
                      input logic we, input logic [1:0] exc);
    exp_t e;
    e.inst = inst; e.wdata = wdata; e.we = we; e.exc = exc;
    sb.push_back(e);
  endtask

  // Waits (bounded) for valid_o, then pops the oldest expectation and compares.
  task automatic wait_wb(input string tag);
    int   n = 0;
    exp_t e;
    while (lsu.valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(lsu.valid_o), 32'h1);
    if (lsu.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'h1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_inst"},  lsu.inst_o, e.inst);
        chk({tag, "_wdata"}, lsu.reg_wdata_o, e.wdata);
        chk({tag, "_we"},    32'(lsu.reg_we_o), 32'(e.we));
        chk({tag, "_exc"},   32'(lsu.exc_o), 32'(e.exc));
      end
    end
  endtask

  logic [31:0] t_addr  [5] = '{32'h102, 32'h100, 32'h101, 32'h102, 32'h200};
  logic [2:0]  t_f3    [5] = '{3'b101, 3'b001, 3'b100, 3'b000, 3'b010};
  logic [31:0] t_rdata [5] = '{32'h8123_4567, 32'h0000_8001, 32'h0000_F000, 32'h007F_0000, 32'hDEAD_BEEF};
  logic [31:0] t_exp   [5] = '{32'h0000_8123, 32'hFFFF_8001, 32'h0000_00F0, 32'h0000_007F, 32'hDEAD_BEEF};
  logic [3:0]  t_sel   [5] = '{4'b1100, 4'b0011, 4'b0010, 4'b0100, 4'b1111};

  initial begin
    int sc;
    int n;
    idle();
    op(32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    idle();
    lsu.bus_ack_i   = 1'b0;
    lsu.bus_rdata_i = 32'h0;
    tick();
    tick();
    chk("rst_valid", 32'(lsu.valid_o), 32'h0);
    chk("rst_stall", 32'(lsu.stall_o), 32'h0);
    chk("rst_bus_req", 32'(lsu.bus_req_o), 32'h0);
    chk("rst_exc", 32'(lsu.exc_o), 32'h0);
    rst = 1'b0;
    tick();

    // ALU op: one-cycle latency
    op(32'hA000_0001, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234);
    push(32'hA000_0001, 32'h1234, 1'b1, 2'b00);
    tick();
    idle();
    chk("alu_stall", 32'(lsu.stall_o), 32'h0);
    wait_wb("alu");
    tick();
    chk("bubble_valid", 32'(lsu.valid_o), 32'h0);
    chk("bubble_we", 32'(lsu.reg_we_o), 32'h0);

    // Flushed op in IDLE is dropped
    op(32'hA000_0002, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h9999);
    lsu.flush_i = 1'b1;
    tick();
    idle();
    chk("flush_idle_valid", 32'(lsu.valid_o), 32'h0);

    // LB 0x103, ack in 4th BUSY cycle (also the expiry cycle), ALU held behind it
    op(32'hB000_0003, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0);
    push(32'hB000_0003, 32'hFFFF_FF80, 1'b1, 2'b00);
    tick();
    op(32'hA000_0004, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h5555);
    chk("lb_bus_req", 32'(lsu.bus_req_o), 32'h1);
    chk("lb_bus_addr", lsu.bus_addr_o, 32'h100);
    chk("lb_bus_sel", 32'(lsu.bus_sel_o), 32'b1000);
    chk("lb_bus_we", 32'(lsu.bus_we_o), 32'h0);
    chk("lb_valid_busy", 32'(lsu.valid_o), 32'h0);
    sc = 0;
    for (int c = 0; c < 4; c++) begin
      if (lsu.stall_o === 1'b1) sc++;
      if (c == 3) begin
        lsu.bus_ack_i   = 1'b1;
        lsu.bus_rdata_i = 32'h80FF_FF00;
      end
      tick();
    end
    lsu.bus_ack_i   = 1'b0;
    lsu.bus_rdata_i = 32'h0;
    chk("lb_stall_cycles", 32'(sc), 32'd4);
    chk("lb_stall_after", 32'(lsu.stall_o), 32'h0);
    chk("lb_req_after", 32'(lsu.bus_req_o), 32'h0);
    push(32'hA000_0004, 32'h5555, 1'b1, 2'b00);
    wait_wb("lb");
    tick();
    idle();
    wait_wb("b2b_alu");

    // SH 0x102 with a flush arriving during BUSY
    op(32'hC000_0005, 1'b1, 1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h7777);
    push(32'hC000_0005, 32'h7777, 1'b0, 2'b00);
    tick();
    op(32'hA000_0006, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1);
    lsu.flush_i = 1'b1;
    chk("sh_sel", 32'(lsu.bus_sel_o), 32'b1100);
    chk("sh_wdata", lsu.bus_wdata_o, 32'hABCD_ABCD);
    chk("sh_we", 32'(lsu.bus_we_o), 32'h1);
    tick();
    chk("sh_req_hold", 32'(lsu.bus_req_o), 32'h1);
    idle();
    lsu.bus_ack_i = 1'b1;
    tick();
    lsu.bus_ack_i = 1'b0;
    wait_wb("sh");

    // SB lane replication
    op(32'hC000_0007, 1'b1, 1'b1, 3'b000, 32'h101, 32'h1234_5678, 32'h0);
    push(32'hC000_0007, 32'h0, 1'b0, 2'b00);
    tick();
    idle();
    chk("sb_sel", 32'(lsu.bus_sel_o), 32'b0010);
    chk("sb_wdata", lsu.bus_wdata_o, 32'h7878_7878);
    lsu.bus_ack_i = 1'b1;
    tick();
    lsu.bus_ack_i = 1'b0;
    wait_wb("sb");

    // Misaligned LW and illegal size: no bus access
    op(32'hD000_0008, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h4444);
    push(32'hD000_0008, 32'h4444, 1'b0, 2'b01);
    tick();
    idle();
    chk("lw_mis_req", 32'(lsu.bus_req_o), 32'h0);
    chk("lw_mis_stall", 32'(lsu.stall_o), 32'h0);
    wait_wb("lw_mis");
    op(32'hD000_0009, 1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h3333);
    push(32'hD000_0009, 32'h3333, 1'b0, 2'b01);
    tick();
    idle();
    chk("f3_ill_req", 32'(lsu.bus_req_o), 32'h0);
    wait_wb("f3_ill");

    // Load lane extraction / extension table, ack in first BUSY cycle
    for (int i = 0; i < 5; i++) begin
      op(32'hE000_0000 + 32'(i), 1'b1, 1'b0, t_f3[i], t_addr[i], 32'h0, 32'h0);
      push(32'hE000_0000 + 32'(i), t_exp[i], 1'b1, 2'b00);
      tick();
      idle();
      chk($sformatf("ld%0d_sel", i), 32'(lsu.bus_sel_o), 32'(t_sel[i]));
      chk($sformatf("ld%0d_addr", i), lsu.bus_addr_o, t_addr[i] & ~32'h3);
      lsu.bus_ack_i   = 1'b1;
      lsu.bus_rdata_i = t_rdata[i];
      tick();
      lsu.bus_ack_i   = 1'b0;
      lsu.bus_rdata_i = 32'h0;
      wait_wb($sformatf("ld%0d", i));
    end

    // Timeout: no ack, request held for exactly 4 BUSY cycles
    op(32'hF000_000A, 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h2222);
    push(32'hF000_000A, 32'h2222, 1'b0, 2'b10);
    tick();
    idle();
    n = 0;
    while (lsu.bus_req_o === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    chk("tmo_req_cycles", 32'(n), 32'd4);
    wait_wb("tmo");

    // Async reset mid-BUSY drops the request immediately
    op(32'hF000_000B, 1'b1, 1'b1, 3'b010, 32'h108, 32'h1, 32'h0);
    tick();
    idle();
    chk("rstb_req_before", 32'(lsu.bus_req_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstb_req_async", 32'(lsu.bus_req_o), 32'h0);
    chk("rstb_stall_async", 32'(lsu.stall_o), 32'h0);
    tick();
    rst = 1'b0;
    op(32'hA000_000C, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hBEEF);
    push(32'hA000_000C, 32'hBEEF, 1'b1, 2'b00);
    tick();
    idle();
    wait_wb("post_rst");

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
